ps2_rx: RTL and testbench

PS/2 device-to-host serial receiver. Synchronises and filters the raw `ps2c`/`ps2d` lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each valid byte as `scan_code` with a one-cycle `scan_done_tick`. It sits directly upstream of the keyboard key-tracking controller, which consumes `scan_code`/`scan_done_tick` unchanged. Bad frames raise error ticks and are never forwarded.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_filter.sv | 41 ++++
 rtl/ps2_rx.sv | 136 +++++++++++++
 tb/tb_ps2_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types: FSM states, frame layout and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  // Frame as it sits in the receive register once the stop bit has arrived.
  typedef struct packed {
    logic                     stop;
    logic                     parity;
    logic [PS2_DATA_BITS-1:0] data;
    logic                     start;
  } ps2_frame_t;

  // Odd parity over data plus parity bit.
  function automatic logic ps2_parity_ok(input ps2_frame_t f);
    return ^{f.parity, f.data};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, FILTER_LEN-sample level filter,
// and a one-cycle pulse on each filtered 1->0 transition.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c,
  output logic fall_edge
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] shreg;
  logic                  filt_clk;
  logic                  filt_nx;

  // Level only moves when the whole window agrees; anything shorter is a glitch.
  always_comb begin
    filt_nx = filt_clk;
    if (&shreg) begin
      filt_nx = 1'b1;
    end else if (~|shreg) begin
      filt_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync      <= 2'b11;
      shreg     <= '1;
      filt_clk  <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      sync      <= {sync[0], ps2c};
      shreg     <= {shreg[FILTER_LEN-2:0], sync[1]};
      filt_clk  <= filt_nx;
      fall_edge <= filt_clk & ~filt_nx;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deframes start / 8 data LSB-first / odd parity / stop
// frames on the filtered clock and reports each byte or error with a one-cycle tick.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps2c,
  input  logic                     ps2d,
  input  logic                     rx_en,
  output logic [PS2_DATA_BITS-1:0] scan_code,
  output logic                     scan_done_tick,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = $clog2(PS2_FRAME_BITS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PS2_FRAME_BITS - 1);
  localparam int unsigned RX_W = PS2_FRAME_BITS - 1;

  logic                     fall_edge;
  logic [1:0]               d_sync;
  logic                     d;
  ps2_state_e               state, state_nx;
  logic [RX_W-1:0]          rx_bits, rx_bits_nx;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_nx;
  logic [TO_W-1:0]          to_cnt, to_cnt_nx;
  logic [PS2_DATA_BITS-1:0] code_nx;
  logic                     done_nx, perr_nx, ferr_nx;
  ps2_frame_t               frame_c;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2c      (ps2c),
    .fall_edge (fall_edge)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_sync <= 2'b11;
    end else begin
      d_sync <= {d_sync[0], ps2d};
    end
  end

  assign d = d_sync[1];

  // Ten held bits plus the live data line form the full 11-bit frame on the stop edge,
  // so the verdict can be registered in the same edge and appear one cycle later.
  assign frame_c = ps2_frame_t'({d, rx_bits});

  always_comb begin
    state_nx   = state;
    rx_bits_nx = rx_bits;
    bit_cnt_nx = bit_cnt;
    to_cnt_nx  = to_cnt;
    code_nx    = scan_code;
    done_nx    = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall_edge && rx_en && !d) begin
          rx_bits_nx = {d, rx_bits[RX_W-1:1]};
          bit_cnt_nx = CNT_LOAD;
          to_cnt_nx  = '0;
          state_nx   = SHIFT;
        end
      end

      SHIFT: begin
        if (fall_edge) begin
          rx_bits_nx = {d, rx_bits[RX_W-1:1]};
          bit_cnt_nx = bit_cnt - CNT_W'(1);
          to_cnt_nx  = '0;
          if (bit_cnt == CNT_W'(1)) begin
            state_nx = CHECK;
            if (!frame_c.stop || frame_c.start) begin
              ferr_nx = 1'b1;
            end else if (!ps2_parity_ok(frame_c)) begin
              perr_nx = 1'b1;
            end else begin
              code_nx = frame_c.data;
              done_nx = 1'b1;
            end
          end
        end else if (to_cnt == TO_LAST) begin
          ferr_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end

      CHECK: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rx_bits        <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      scan_code      <= '0;
      scan_done_tick <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_nx;
      rx_bits        <= rx_bits_nx;
      bit_cnt        <= bit_cnt_nx;
      to_cnt         <= to_cnt_nx;
      scan_code      <= code_nx;
      scan_done_tick <= done_nx;
      parity_err     <= perr_nx;
      frame_err      <= ferr_nx;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: vector table, hand-written corner sequences and random frames
// checked against an event-level model of the receiver.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int FILT = 8;
  localparam int TMO  = 400;
  localparam int HP   = 30;

  localparam logic [1:0] EV_TICK = 2'd0;
  localparam logic [1:0] EV_PERR = 2'd1;
  localparam logic [1:0] EV_FERR = 2'd2;
  localparam logic [1:0] EV_BAD  = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] code;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       en;
    logic       en_drop;
    int         exp_events;
    logic [1:0] exp_kind;
    logic [7:0] exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] scan_code;
  logic       scan_done_tick;
  logic       parity_err;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;

  ev_t        got_q[$];
  logic [7:0] prev_code;

  ps2_rx #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2c           (ps2c),
    .ps2d           (ps2d),
    .rx_en          (rx_en),
    .scan_code      (scan_code),
    .scan_done_tick (scan_done_tick),
    .parity_err     (parity_err),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Event recorder: one entry per tick; overlapping ticks or a code change without a tick log EV_BAD.
  always @(negedge clk) begin
    int n;
    n = int'(scan_done_tick) + int'(parity_err) + int'(frame_err);
    if (reset_n === 1'b1) begin
      if (n > 1)                got_q.push_back('{EV_BAD, scan_code});
      else if (scan_done_tick)  got_q.push_back('{EV_TICK, scan_code});
      else if (parity_err)      got_q.push_back('{EV_PERR, scan_code});
      else if (frame_err)       got_q.push_back('{EV_FERR, scan_code});
      if (scan_code !== prev_code && !scan_done_tick) got_q.push_back('{EV_BAD, scan_code});
    end
    prev_code = scan_code;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits in wire order (index 0 first): start, data LSB-first, odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_par,
                                             input logic bad_stop);
    logic par;
    par = ($countones(data) % 2 == 0);
    return {~bad_stop, par ^ bad_par, data, 1'b0};
  endfunction

  // Drives frame bits first..last; glitch_at puts a 3-cycle low pulse in that bit's high phase.
  task automatic send_bits(input logic [10:0] frame, input int first, input int last,
                           input int glitch_at);
    for (int i = first; i <= last; i++) begin
      ps2d = frame[i];
      wait_cyc(10);
      if (i == glitch_at) begin
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
      end else begin
        wait_cyc(3);
      end
      wait_cyc(HP - 13);
      ps2c = 1'b0;
      wait_cyc(HP);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  initial begin
    logic [10:0] f;
    int          base, lat, nev, mode, nbits, gl;
    logic [7:0]  data, model_code;
    logic        bp, bs, en;
    ev_t         exp_q[$];
    vec_t        vt[12];

    vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'h1C};
    vt[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'hF0};
    vt[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'h1C};
    vt[3]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1, EV_PERR, 8'h1C};
    vt[4]  = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1, EV_FERR, 8'h1C};
    vt[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'h00};
    vt[6]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'hFF};
    vt[7]  = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 0, EV_BAD,  8'hFF};
    vt[8]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b1, 1, EV_TICK, 8'h29};
    vt[9]  = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1, EV_FERR, 8'h29};
    vt[10] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1, EV_TICK, 8'h80};
    vt[11] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1, EV_PERR, 8'h80};

    reset_n = 1'b0;
    ps2c    = 1'b1;
    ps2d    = 1'b1;
    rx_en   = 1'b1;
    wait_cyc(3);
    check("reset_scan_code", 32'(scan_code), 32'h00);
    check("reset_done_tick", 32'(scan_done_tick), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < 12; i++) begin
      base  = got_q.size();
      f     = make_frame(vt[i].data, vt[i].bad_par, vt[i].bad_stop);
      rx_en = vt[i].en;
      send_bits(f, 0, 0, -1);
      if (vt[i].en_drop) rx_en = 1'b0;
      send_bits(f, 1, 10, -1);
      wait_cyc(20);
      rx_en = 1'b1;
      nev = got_q.size() - base;
      check($sformatf("vec%0d_events", i), 32'(nev), 32'(vt[i].exp_events));
      if (nev > 0 && vt[i].exp_events > 0)
        check($sformatf("vec%0d_kind", i), 32'(got_q[base].kind), 32'(vt[i].exp_kind));
      check($sformatf("vec%0d_code", i), 32'(scan_code), 32'(vt[i].exp_code));
    end

    // Tick must land 12 cycles after the raw stop-bit fall: 2 sync + 8 filter + edge + verdict.
    base = got_q.size();
    f    = make_frame(8'h1C, 1'b0, 1'b0);
    send_bits(f, 0, 9, -1);
    ps2d = f[10];
    wait_cyc(HP);
    ps2c = 1'b0;
    lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lat < 0 && scan_done_tick) lat = k;
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    wait_cyc(20);
    check("tick_latency", 32'(lat), 32'd12);
    check("latency_code", 32'(scan_code), 32'h1C);
    check("latency_events", 32'(got_q.size() - base), 32'd1);

    // Truncated frame: silent until the inter-edge limit, then exactly one frame error.
    base = got_q.size();
    f    = make_frame(8'h33, 1'b0, 1'b0);
    send_bits(f, 0, 4, -1);
    wait_cyc(TMO - 50);
    check("timeout_early", 32'(got_q.size() - base), 32'd0);
    wait_cyc(60);
    check("timeout_events", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("timeout_kind", 32'(got_q[base].kind), 32'(EV_FERR));
    f = make_frame(8'h29, 1'b0, 1'b0);
    send_bits(f, 0, 10, -1);
    wait_cyc(20);
    check("after_timeout_code", 32'(scan_code), 32'h29);

    // Short clock glitches, idle (with data low) and mid-frame on a zero data bit.
    base = got_q.size();
    ps2d = 1'b0;
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(HP);
    ps2d = 1'b1;
    wait_cyc(20);
    check("idle_glitch_events", 32'(got_q.size() - base), 32'd0);
    f = make_frame(8'h5A, 1'b0, 1'b0);
    send_bits(f, 0, 10, 3);
    wait_cyc(20);
    check("glitch_frame_events", 32'(got_q.size() - base), 32'd1);
    check("glitch_frame_code", 32'(scan_code), 32'h5A);

    // Reset after four bits drops the partial frame.
    f = make_frame(8'hE7, 1'b0, 1'b0);
    send_bits(f, 0, 3, -1);
    reset_n = 1'b0;
    wait_cyc(1);
    check("midreset_code", 32'(scan_code), 32'h00);
    check("midreset_tick", 32'(scan_done_tick), 32'h0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(20);
    base = got_q.size();
    f    = make_frame(8'h1C, 1'b0, 1'b0);
    send_bits(f, 0, 10, -1);
    wait_cyc(20);
    check("postreset_events", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("postreset_kind", 32'(got_q[base].kind), 32'(EV_TICK));
    check("postreset_code", 32'(scan_code), 32'h1C);

    // Random frames against an event-level model.
    model_code = 8'h1C;
    base       = got_q.size();
    for (int n = 0; n < 30; n++) begin
      data  = 8'($urandom);
      mode  = int'($urandom_range(0, 9));
      bp    = (mode == 0);
      bs    = (mode == 1);
      en    = (mode != 2);
      nbits = (mode == 3) ? int'($urandom_range(2, 10)) : 11;
      gl    = (mode == 4) ? int'($urandom_range(1, 10)) : -1;
      f     = make_frame(data, bp, bs);
      rx_en = en;
      send_bits(f, 0, nbits - 1, gl);
      rx_en = 1'b1;
      if (nbits < 11) wait_cyc(TMO + 10);
      wait_cyc(int'($urandom_range(20, 60)));
      if (!en) begin
      end else if (nbits < 11 || bs) begin
        exp_q.push_back('{EV_FERR, 8'h00});
      end else if (bp) begin
        exp_q.push_back('{EV_PERR, 8'h00});
      end else begin
        exp_q.push_back('{EV_TICK, data});
        model_code = data;
      end
    end
    nev = got_q.size() - base;
    check("rand_event_count", 32'(nev), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < nev; k++) begin
      check($sformatf("rand%0d_kind", k), 32'(got_q[base + k].kind), 32'(exp_q[k].kind));
      if (exp_q[k].kind == EV_TICK)
        check($sformatf("rand%0d_code", k), 32'(got_q[base + k].code), 32'(exp_q[k].code));
    end
    check("rand_final_code", 32'(scan_code), 32'(model_code));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
